// File: rtl/conv2_pkg.sv
// Shared parameters and the pixel record passed from the shift stage to the pixel buffer.
package conv2_pkg;

   localparam int N_CH   = 16;
   localparam int DATA_W = 8;
   localparam int N_PIX  = 64;
   localparam int IDX_W  = $clog2(N_PIX);
   localparam int BIT_W  = $clog2(DATA_W);

   typedef struct packed {
      logic [N_CH*DATA_W-1:0] data;
      logic [IDX_W-1:0]       idx;
      logic                   last;
   } pix_t;

endpackage

// File: rtl/conv2_deserializer_if.sv
// Serial input and pixel output bundle of the conv2 deserializer; slave = the deserializer itself.
interface conv2_deserializer_if;
   import conv2_pkg::*;

   logic [N_CH-1:0]        bit_in;
   logic                   valid_in;
   logic [N_CH*DATA_W-1:0] pix_data;
   logic                   pix_valid;
   logic                   pix_ready;
   logic [IDX_W-1:0]       pix_idx;
   logic                   pix_last;
   logic                   frame_done;
   logic                   overflow;

   modport slave (
      input  bit_in, valid_in, pix_ready,
      output pix_data, pix_valid, pix_idx, pix_last, frame_done, overflow
   );

   modport master (
      output bit_in, valid_in, pix_ready,
      input  pix_data, pix_valid, pix_idx, pix_last, frame_done, overflow
   );

endinterface

// File: rtl/conv2_deserializer_pix_fifo.sv
// Pixel buffer with a registered head; the presented pixel still occupies its slot until popped.
module pix_fifo
   import conv2_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  pix_t i_din,
   input  logic i_pop,
   output pix_t o_dout,
   output logic o_valid,
   output logic o_full,
   output logic o_empty
);

   localparam int             PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

   pix_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   pix_t             r_dout;
   logic             r_valid;

   logic             w_pop;
   logic             w_push;
   logic [PTR_W-1:0] w_rd_next;

   assign o_full    = (r_count == CNT_FULL);
   assign o_empty   = (r_count == '0);
   assign w_pop     = i_pop & r_valid;
   // a pop in the same cycle frees the slot, so a push into a full buffer still lands
   assign w_push    = i_push & (~o_full | w_pop);
   assign w_rd_next = r_rd_ptr + PTR_W'(1);

   assign o_dout  = r_dout;
   assign o_valid = r_valid;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= w_rd_next;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: ;
         endcase

         // head reloads only from already-stored entries, so a fresh push shows one cycle later
         if (w_pop) begin
            r_valid <= (r_count > CNT_ONE);
            if (r_count > CNT_ONE) r_dout <= r_mem[w_rd_next];
         end else if (!r_valid) begin
            r_valid <= ~o_empty;
            if (!o_empty) r_dout <= r_mem[r_rd_ptr];
         end
      end
   end

endmodule

// File: rtl/conv2_deserializer.sv
// Collects DATA_W serial bits per conv2 channel into pixels and hands them downstream
// through a small buffer, tracking raster position and flagging dropped pixels.
module conv2_deserializer
   import conv2_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   conv2_deserializer_if.slave  bus
);

   logic [N_CH*DATA_W-1:0] r_sr;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic [IDX_W-1:0]       r_pos_cnt;
   logic                   r_overflow;
   logic                   r_frame_done;

   logic                   w_complete;
   logic                   w_pop;
   pix_t                   w_pix;
   pix_t                   w_head;
   logic                   w_head_valid;
   logic                   w_full;
   logic                   w_empty;

   assign w_complete = bus.valid_in && (r_bit_cnt == BIT_W'(DATA_W-1));
   assign w_pop      = w_head_valid & bus.pix_ready;

   always_comb begin
      w_pix = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_pix.data[k*DATA_W +: DATA_W] = {r_sr[k*DATA_W +: DATA_W-1], bus.bit_in[k]};
      end
      w_pix.idx  = r_pos_cnt;
      w_pix.last = (r_pos_cnt == IDX_W'(N_PIX-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr         <= '0;
         r_bit_cnt    <= '0;
         r_pos_cnt    <= '0;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_pop & w_head.last;
         if (w_complete & w_full & ~w_pop) r_overflow <= 1'b1;

         if (bus.valid_in) begin
            r_sr      <= w_pix.data;
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + BIT_W'(1);
         end

         // dropped pixels still advance the position so indices stay aligned with the producer
         if (w_complete) begin
            r_pos_cnt <= (r_pos_cnt == IDX_W'(N_PIX-1)) ? '0 : r_pos_cnt + IDX_W'(1);
         end
      end
   end

   pix_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_pix_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_complete),
      .i_din   (w_pix),
      .i_pop   (bus.pix_ready),
      .o_dout  (w_head),
      .o_valid (w_head_valid),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) assert (!(w_empty && w_head_valid));
   end

   assign bus.pix_data   = w_head.data;
   assign bus.pix_idx    = w_head.idx;
   assign bus.pix_last   = w_head.last;
   assign bus.pix_valid  = w_head_valid;
   assign bus.frame_done = r_frame_done;
   assign bus.overflow   = r_overflow;

endmodule
